// File: rtl/load_store_unit.sv
// load_store_unit: req/ack data-memory access for loads/stores with stall, extension and timeout.
// Optional misaligned-access trap enabled by defining MISALIGN_TRAP_EN.
module load_store_unit #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        read_en,
  input  logic        write_en,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        done,
  output logic        stall,
  output logic        err,
  output logic        trap,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_be,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  input  logic        bus_err
);
  typedef enum logic [1:0] {IDLE, BUS, DONE} state_t;
  state_t state, state_n;
  logic [31:0] addr_q, wdata_q, cnt, rsh, hsh, load_val;
  logic [2:0] f3_q;
  logic we_q, err_q, req, bad_in, mis_in, tmo, in_bus;
  logic [3:0] st_be;
  logic [31:0] st_wd;
  function automatic logic f3_ok(input logic [2:0] f, input logic we);
    return we ? (f inside {3'b000, 3'b001, 3'b010}) : (f inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
  endfunction
`ifdef MISALIGN_TRAP_EN
  function automatic logic is_mis(input logic [2:0] f, input logic [1:0] a);
    return (f[1:0] == 2'b01 && a[0]) || (f[1:0] == 2'b10 && a != 2'b00);
  endfunction
  assign mis_in = is_mis(funct3, addr[1:0]);
  assign trap = (state == DONE) && f3_ok(f3_q, we_q) && is_mis(f3_q, addr_q[1:0]);
`else
  assign mis_in = 1'b0;
  assign trap = 1'b0;
`endif
  assign req = read_en | write_en;
  assign bad_in = !f3_ok(funct3, write_en);
  assign tmo = (TIMEOUT_CYCLES != 0) && (cnt == 32'(TIMEOUT_CYCLES - 1));
  assign in_bus = state == BUS;
  assign stall = (state == IDLE && req) || in_bus;
  assign done = state == DONE;
  assign err = err_q;
  assign rsh = bus_rdata >> {addr_q[1:0], 3'b000};
  assign hsh = bus_rdata >> {addr_q[1], 4'b0000};
  always_comb begin
    state_n = state == IDLE ? (req ? ((bad_in || mis_in) ? DONE : BUS) : IDLE)
            : state == BUS  ? ((bus_ack || bus_err || tmo) ? DONE : BUS)
            : IDLE;
    st_be = f3_q[1:0] == 2'b00 ? 4'b0001 << addr_q[1:0]
          : f3_q[1:0] == 2'b01 ? (addr_q[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    st_wd = f3_q[1:0] == 2'b00 ? {4{wdata_q[7:0]}}
          : f3_q[1:0] == 2'b01 ? {2{wdata_q[15:0]}} : wdata_q;
    load_val = f3_q[1] ? bus_rdata
             : f3_q[0] ? {{16{~f3_q[2] & hsh[15]}}, hsh[15:0]}
             : {{24{~f3_q[2] & rsh[7]}}, rsh[7:0]};
  end
  assign bus_req = in_bus;
  assign bus_we = in_bus & we_q;
  assign bus_addr = in_bus ? {addr_q[31:2], 2'b00} : 32'b0;
  assign bus_be = in_bus ? (we_q ? st_be : 4'b1111) : 4'b0000;
  assign bus_wdata = in_bus ? st_wd : 32'b0;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      addr_q <= '0;
      wdata_q <= '0;
      f3_q <= '0;
      we_q <= 1'b0;
      err_q <= 1'b0;
      rdata <= '0;
      cnt <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && req) begin
        addr_q <= addr;
        wdata_q <= wdata;
        f3_q <= funct3;
        we_q <= write_en;
        err_q <= bad_in || mis_in;
        cnt <= '0;
      end
      if (in_bus) begin
        cnt <= cnt + {31'b0, ~&cnt};
        if (bus_err || (!bus_ack && tmo)) err_q <= 1'b1;
        else if (bus_ack && !we_q) rdata <= load_val;
      end
    end
  end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed vectors for load_store_unit with hand-computed expectations.
module tb_load_store_unit;
  logic clk = 1'b0, rst = 1'b1;
  logic read_en = 1'b0, write_en = 1'b0;
  logic [2:0] funct3 = 3'b0;
  logic [31:0] addr = '0, wdata = '0, bus_rdata = '0;
  logic bus_ack = 1'b0, bus_err = 1'b0;
  logic [31:0] rdata, bus_addr, bus_wdata;
  logic done, stall, err, trap, bus_req, bus_we;
  logic [3:0] bus_be;
  int n_vec = 0, n_bad = 0;
  int n_stall, n_req, done_cyc;
  logic [31:0] got_addr, got_wd;
  logic [3:0] got_be;
  logic got_we, got_err, got_trap, saw_done, done_after, err_after;

  load_store_unit dut (
    .clk(clk), .rst(rst), .read_en(read_en), .write_en(write_en), .funct3(funct3),
    .addr(addr), .wdata(wdata), .rdata(rdata), .done(done), .stall(stall), .err(err),
    .trap(trap), .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_be(bus_be), .bus_ack(bus_ack), .bus_rdata(bus_rdata),
    .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic access(input logic w, input logic both, input logic [2:0] f,
                        input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
                        input int ack_at, input int err_at);
    int bc = 0;
    n_stall = 0; n_req = 0; done_cyc = -1; saw_done = 1'b0;
    got_addr = '0; got_wd = '0; got_be = '0; got_we = 1'b0; got_err = 1'b0; got_trap = 1'b0;
    @(negedge clk);
    read_en = !w || both; write_en = w; funct3 = f; addr = a; wdata = wd; bus_rdata = rd;
    for (int i = 0; i < 40 && !saw_done; i++) begin
      #1;
      if (bus_req) begin
        bc++;
        if (bc == 1) begin
          got_addr = bus_addr; got_wd = bus_wdata; got_be = bus_be; got_we = bus_we;
        end
        bus_ack = (bc == ack_at);
        bus_err = (bc == err_at);
      end else begin
        bus_ack = 1'b0; bus_err = 1'b0;
      end
      n_stall += int'(stall);
      n_req += int'(bus_req);
      if (done) begin
        saw_done = 1'b1; done_cyc = i; got_err = err; got_trap = trap;
        read_en = 1'b0; write_en = 1'b0;
      end
      @(negedge clk);
    end
    bus_ack = 1'b0; bus_err = 1'b0;
    #1;
    done_after = done; err_after = err;
    if (!saw_done) chk("done_seen", 32'(saw_done), 32'd1);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    #1;
    chk("rst_bus_req", 32'(bus_req), 0);
    chk("rst_stall", 32'(stall), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_trap", 32'(trap), 0);
    chk("rst_rdata", rdata, 0);
    rst = 1'b0;

    access(1, 0, 3'b010, 32'h100, 32'hDEADBEEF, 0, 2, 0);
    chk("sw_addr", got_addr, 32'h100);
    chk("sw_be", 32'(got_be), 32'hF);
    chk("sw_we", 32'(got_we), 1);
    chk("sw_wdata", got_wd, 32'hDEADBEEF);
    chk("sw_stall", n_stall, 3);
    chk("sw_req", n_req, 2);
    chk("sw_done_cyc", done_cyc, 3);
    chk("sw_done_pulse", 32'(done_after), 0);
    chk("sw_err", 32'(got_err), 0);

    access(0, 0, 3'b000, 32'h103, 0, 32'h80FF1234, 1, 0);
    chk("lb_rdata", rdata, 32'hFFFFFF80);
    chk("lb_be", 32'(got_be), 32'hF);
    chk("lb_we", 32'(got_we), 0);
    chk("lb_latency", done_cyc, 2);
    access(0, 0, 3'b100, 32'h103, 0, 32'h80FF1234, 1, 0);
    chk("lbu_rdata", rdata, 32'h00000080);
    access(0, 0, 3'b101, 32'h102, 0, 32'h80FF1234, 1, 0);
    chk("lhu_rdata", rdata, 32'h000080FF);
    access(0, 0, 3'b001, 32'h102, 0, 32'h80FF1234, 1, 0);
    chk("lh_rdata", rdata, 32'hFFFF80FF);
    access(0, 0, 3'b001, 32'h100, 0, 32'h80FF1234, 1, 0);
    chk("lh_lo_rdata", rdata, 32'h00001234);

    access(1, 0, 3'b001, 32'h202, 32'h0000ABCD, 0, 1, 0);
    chk("sh_addr", got_addr, 32'h200);
    chk("sh_be", 32'(got_be), 32'hC);
    chk("sh_wdata", got_wd, 32'hABCDABCD);
    access(1, 0, 3'b000, 32'h101, 32'h000000A5, 0, 1, 0);
    chk("sb_be", 32'(got_be), 32'h2);
    chk("sb_wdata", got_wd, 32'hA5A5A5A5);
    access(1, 1, 3'b010, 32'h300, 32'h11223344, 0, 1, 0);
    chk("both_we", 32'(got_we), 1);

    access(0, 0, 3'b010, 32'h104, 0, 32'h12345678, 1, 0);
    chk("lw_rdata", rdata, 32'h12345678);
    access(0, 0, 3'b010, 32'h108, 0, 32'hCAFE0000, 0, 0);
    chk("tmo_req", n_req, 16);
    chk("tmo_err", 32'(got_err), 1);
    chk("tmo_rdata", rdata, 32'h12345678);
    chk("tmo_err_held", 32'(err_after), 1);
    access(0, 0, 3'b010, 32'h108, 0, 32'hCAFE0000, 0, 3);
    chk("berr_req", n_req, 3);
    chk("berr_done_cyc", done_cyc, 4);
    chk("berr_err", 32'(got_err), 1);
    chk("berr_rdata", rdata, 32'h12345678);
    access(0, 0, 3'b011, 32'h100, 0, 0, 1, 0);
    chk("bad_req", n_req, 0);
    chk("bad_err", 32'(got_err), 1);
    chk("bad_done_cyc", done_cyc, 1);
    access(1, 0, 3'b100, 32'h100, 0, 0, 1, 0);
    chk("bad_st_req", n_req, 0);
    chk("bad_st_err", 32'(got_err), 1);

    access(0, 0, 3'b010, 32'h101, 0, 32'h55AA33CC, 1, 0);
`ifdef MISALIGN_TRAP_EN
    chk("mis_req", n_req, 0);
    chk("mis_done_cyc", done_cyc, 1);
    chk("mis_trap", 32'(got_trap), 1);
    chk("mis_err", 32'(got_err), 1);
`else
    chk("mis_addr", got_addr, 32'h100);
    chk("mis_rdata", rdata, 32'h55AA33CC);
    chk("mis_trap", 32'(got_trap), 0);
    chk("mis_err", 32'(got_err), 0);
`endif

    @(negedge clk);
    read_en = 1'b1; write_en = 1'b0; funct3 = 3'b010; addr = 32'h400; bus_rdata = 32'h0BADF00D;
    @(negedge clk);
    #1;
    chk("rstm_bus1", 32'(bus_req), 1);
    @(negedge clk);
    rst = 1'b1; read_en = 1'b0;
    @(negedge clk);
    #1;
    chk("rstm_req", 32'(bus_req), 0);
    chk("rstm_stall", 32'(stall), 0);
    chk("rstm_done", 32'(done), 0);
    chk("rstm_rdata", rdata, 0);
    rst = 1'b0;
    access(0, 0, 3'b010, 32'h400, 0, 32'h0BADF00D, 1, 0);
    chk("post_rst_rdata", rdata, 32'h0BADF00D);
    chk("post_rst_err", 32'(got_err), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
